// File: rtl/vegeta_tile_scheduler.sv
// rtl/vegeta_tile_scheduler.sv - tiled GEMM job sequencer driving the VEGETA array controller
module vegeta_tile_scheduler #(
  parameter int DIM_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_job_valid,
  output logic               o_job_ready,
  input  logic [DIM_W-1:0]   i_job_m_tiles,
  input  logic [DIM_W-1:0]   i_job_n_tiles,
  input  logic [DIM_W-1:0]   i_job_k_tiles,
  input  logic               i_abort,
  output logic               o_start_multiplication,
  input  logic               i_compute_done,
  output logic [DIM_W-1:0]   o_tile_m,
  output logic [DIM_W-1:0]   o_tile_n,
  output logic [DIM_W-1:0]   o_tile_k,
  output logic               o_first_k,
  output logic               o_last_k,
  output logic               o_busy,
  output logic               o_job_done,
  output logic               o_job_aborted,
  output logic [3*DIM_W-1:0] o_tiles_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_ADVANCE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [DIM_W-1:0]   ONE   = DIM_W'(1);
  localparam logic [3*DIM_W-1:0] ONE_T = (3*DIM_W)'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_compute_done_q;
  logic [DIM_W-1:0]   r_m_tiles;
  logic [DIM_W-1:0]   r_n_tiles;
  logic [DIM_W-1:0]   r_k_tiles;
  logic [DIM_W-1:0]   r_tile_m;
  logic [DIM_W-1:0]   r_tile_n;
  logic [DIM_W-1:0]   r_tile_k;
  logic               r_first_k;
  logic               r_last_k;
  logic               r_abort_pending;
  logic               r_job_aborted;
  logic [3*DIM_W-1:0] r_tiles_done;

  logic               w_done_rise;
  logic               w_zero_dim;
  logic               w_k_wrap;
  logic               w_n_wrap;
  logic               w_m_wrap;
  logic               w_last_tile;
  logic               w_aborted_next;
  logic [DIM_W-1:0]   w_k_next;
  logic [DIM_W-1:0]   w_n_next;
  logic [DIM_W-1:0]   w_m_next;

  // Only a fresh rising edge of the done level marks tile completion; a level
  // left high by the previous tile must not retire the next one.
  assign w_done_rise = i_compute_done & ~r_compute_done_q;
  assign w_zero_dim  = (i_job_m_tiles == '0) | (i_job_n_tiles == '0) | (i_job_k_tiles == '0);

  // Wrap tests compare against count-1, so a count of 2^DIM_W-1 never overflows.
  assign w_k_wrap    = (r_tile_k == r_k_tiles - ONE);
  assign w_n_wrap    = (r_tile_n == r_n_tiles - ONE);
  assign w_m_wrap    = (r_tile_m == r_m_tiles - ONE);
  assign w_last_tile = w_k_wrap & w_n_wrap & w_m_wrap;

  // K innermost, then N, then M.
  assign w_k_next = w_k_wrap ? '0 : r_tile_k + ONE;
  assign w_n_next = w_k_wrap ? (w_n_wrap ? '0 : r_tile_n + ONE) : r_tile_n;
  assign w_m_next = (w_k_wrap & w_n_wrap) ? r_tile_m + ONE : r_tile_m;

  assign o_tile_m      = r_tile_m;
  assign o_tile_n      = r_tile_n;
  assign o_tile_k      = r_tile_k;
  assign o_first_k     = r_first_k;
  assign o_last_k      = r_last_k;
  assign o_tiles_done  = r_tiles_done;
  assign o_job_aborted = r_job_aborted;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    w_state_next           = r_state;
    w_aborted_next         = 1'b0;
    o_job_ready            = 1'b0;
    o_start_multiplication = 1'b0;
    o_busy                 = 1'b1;
    o_job_done             = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_job_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_job_valid) begin
          w_state_next = w_zero_dim ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_start_multiplication = 1'b1;
        w_state_next           = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_rise) begin
          if (w_last_tile) begin
            w_state_next = S_DONE;
          end else if (r_abort_pending | i_abort) begin
            w_state_next   = S_DONE;
            w_aborted_next = 1'b1;
          end else begin
            w_state_next = S_ADVANCE;
          end
        end
      end
      S_ADVANCE: begin
        if (i_abort) begin
          w_state_next   = S_DONE;
          w_aborted_next = 1'b1;
        end else begin
          w_state_next = S_ISSUE;
        end
      end
      S_DONE: begin
        o_job_done   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Job dimensions, tile indices, qualifiers, abort latch and completion count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_compute_done_q <= 1'b0;
      r_m_tiles        <= '0;
      r_n_tiles        <= '0;
      r_k_tiles        <= '0;
      r_tile_m         <= '0;
      r_tile_n         <= '0;
      r_tile_k         <= '0;
      r_first_k        <= 1'b0;
      r_last_k         <= 1'b0;
      r_abort_pending  <= 1'b0;
      r_job_aborted    <= 1'b0;
      r_tiles_done     <= '0;
    end else begin
      r_compute_done_q <= i_compute_done;
      r_job_aborted    <= w_aborted_next;
      case (r_state)
        S_IDLE: begin
          if (i_job_valid) begin
            r_m_tiles       <= i_job_m_tiles;
            r_n_tiles       <= i_job_n_tiles;
            r_k_tiles       <= i_job_k_tiles;
            r_tile_m        <= '0;
            r_tile_n        <= '0;
            r_tile_k        <= '0;
            r_first_k       <= ~w_zero_dim;
            r_last_k        <= ~w_zero_dim & (i_job_k_tiles == ONE);
            r_tiles_done    <= '0;
            r_abort_pending <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (i_abort) begin
            r_abort_pending <= 1'b1;
          end
        end
        S_WAIT: begin
          if (i_abort) begin
            r_abort_pending <= 1'b1;
          end
          if (w_done_rise) begin
            r_tiles_done <= r_tiles_done + ONE_T;
          end
        end
        S_ADVANCE: begin
          r_tile_m  <= w_m_next;
          r_tile_n  <= w_n_next;
          r_tile_k  <= w_k_next;
          r_first_k <= (w_k_next == '0);
          r_last_k  <= (w_k_next == r_k_tiles - ONE);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vegeta_tile_scheduler.sv
// tb/tb_vegeta_tile_scheduler.sv - randomized and directed checks of the tile scheduler against a nested-loop job model
module tb_vegeta_tile_scheduler;
  localparam int DIM_W = 4;

  typedef struct {
    int m;
    int n;
    int k;
    int fk;
    int lk;
    int cyc;
  } start_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               job_valid;
  logic               job_ready;
  logic [DIM_W-1:0]   job_m;
  logic [DIM_W-1:0]   job_n;
  logic [DIM_W-1:0]   job_k;
  logic               abort;
  logic               start_mul;
  logic               compute_done;
  logic [DIM_W-1:0]   tile_m;
  logic [DIM_W-1:0]   tile_n;
  logic [DIM_W-1:0]   tile_k;
  logic               first_k;
  logic               last_k;
  logic               busy;
  logic               job_done;
  logic               job_aborted;
  logic [3*DIM_W-1:0] tiles_done;

  int errors = 0;
  int checks = 0;

  // Observations collected by run_job.
  start_t obs[$];
  start_t exp_q[$];
  int done_cnt, done_cyc, done_tiles, done_aborted, rise_cyc, ready_after, done_after, timed_out;

  // Array-controller model state.
  bit arr_active = 1'b0;
  int arr_age = 0;

  vegeta_tile_scheduler #(.DIM_W(DIM_W)) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_job_valid            (job_valid),
    .o_job_ready            (job_ready),
    .i_job_m_tiles          (job_m),
    .i_job_n_tiles          (job_n),
    .i_job_k_tiles          (job_k),
    .i_abort                (abort),
    .o_start_multiplication (start_mul),
    .i_compute_done         (compute_done),
    .o_tile_m               (tile_m),
    .o_tile_n               (tile_n),
    .o_tile_k               (tile_k),
    .o_first_k              (first_k),
    .o_last_k               (last_k),
    .o_busy                 (busy),
    .o_job_done             (job_done),
    .o_job_aborted          (job_aborted),
    .o_tiles_done           (tiles_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference job: every tile of an MxNxK walk, K innermost.
  task automatic build_model(input int m, input int n, input int k);
    start_t t;
    exp_q.delete();
    for (int mi = 0; mi < m; mi++)
      for (int ni = 0; ni < n; ni++)
        for (int ki = 0; ki < k; ki++) begin
          t.m = mi; t.n = ni; t.k = ki;
          t.fk = (ki == 0) ? 1 : 0;
          t.lk = (ki == k - 1) ? 1 : 0;
          t.cyc = 0;
          exp_q.push_back(t);
        end
  endtask

  // Presents a job in the current idle cycle and plays the array controller:
  // done level drops after `hold` cycles and rises `d` cycles after each start.
  task automatic run_job(input int m, input int n, input int k, input int d, input int hold,
                         input int abort_tile, input int abort_off);
    int rel, abort_cyc;
    bit seen_done;
    start_t s;
    obs.delete();
    done_cnt = 0; done_cyc = -1; done_tiles = -1; done_aborted = -1;
    rise_cyc = -1; ready_after = 0; done_after = 0; timed_out = 0;
    abort_cyc = -1; seen_done = 0; rel = 0;
    job_m = DIM_W'(m); job_n = DIM_W'(n); job_k = DIM_W'(k);
    job_valid = 1'b1;
    while (!seen_done && rel < 3000) begin
      tick();
      rel++;
      job_valid = 1'b0;
      abort = 1'b0;
      if (start_mul) begin
        s.m = int'(tile_m); s.n = int'(tile_n); s.k = int'(tile_k);
        s.fk = int'(first_k); s.lk = int'(last_k); s.cyc = rel;
        obs.push_back(s);
        arr_active = 1'b1;
        arr_age = 0;
        if (obs.size() - 1 == abort_tile) abort_cyc = rel + abort_off;
      end else if (arr_active) begin
        arr_age++;
        if (arr_age > hold) begin
          if (arr_age < d) compute_done = 1'b0;
          else begin
            compute_done = 1'b1;
            arr_active = 1'b0;
            rise_cyc = rel;
          end
        end
      end
      if (job_done) begin
        done_cnt++;
        done_cyc = rel;
        done_tiles = int'(tiles_done);
        done_aborted = int'(job_aborted);
        seen_done = 1'b1;
      end
      if (rel == abort_cyc) abort = 1'b1;
    end
    timed_out = seen_done ? 0 : 1;
    tick();
    abort = 1'b0;
    ready_after = int'(job_ready);
    done_after = int'(job_done);
  endtask

  task automatic test_reset();
    rst = 1'b1; job_valid = 1'b0; abort = 1'b0; compute_done = 1'b0;
    job_m = '0; job_n = '0; job_k = '0;
    tick(); tick();
    checks++;
    if ({job_ready, start_mul, busy, job_done, job_aborted, first_k, last_k} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 1000000", {job_ready, start_mul, busy, job_done, job_aborted, first_k, last_k});
    end
    checks++;
    if ({tile_m, tile_n, tile_k, tiles_done} !== '0) begin
      errors++;
      $display("FAIL reset_data: got tiles %0d/%0d/%0d done %0d expected all 0", tile_m, tile_n, tile_k, tiles_done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_job();
    build_model(2, 1, 3);
    run_job(2, 1, 3, 5, 0, -1, 0);
    checks++;
    if (timed_out != 0 || done_cnt != 1) begin
      errors++; $display("FAIL full_done_count: got %0d (timeout %0d) expected 1", done_cnt, timed_out);
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("FAIL full_starts: got %0d expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].m != exp_q[i].m || obs[i].n != exp_q[i].n || obs[i].k != exp_q[i].k ||
          obs[i].fk != exp_q[i].fk || obs[i].lk != exp_q[i].lk) begin
        errors++;
        $display("FAIL full_tile%0d: got m%0d n%0d k%0d f%0d l%0d expected m%0d n%0d k%0d f%0d l%0d", i,
                 obs[i].m, obs[i].n, obs[i].k, obs[i].fk, obs[i].lk,
                 exp_q[i].m, exp_q[i].n, exp_q[i].k, exp_q[i].fk, exp_q[i].lk);
      end
      checks++;
      if (obs[i].cyc != ((i == 0) ? 1 : obs[i-1].cyc + 7)) begin
        errors++; $display("FAIL full_start_cycle%0d: got %0d expected %0d", i, obs[i].cyc, (i == 0) ? 1 : obs[i-1].cyc + 7);
      end
    end
    checks++;
    if (done_tiles != 6 || done_aborted != 0) begin
      errors++; $display("FAIL full_result: got tiles %0d aborted %0d expected 6 0", done_tiles, done_aborted);
    end
    checks++;
    if (done_cyc != rise_cyc + 1 || ready_after != 1 || done_after != 0) begin
      errors++; $display("FAIL full_done_timing: got done %0d ready %0d pulse2 %0d expected %0d 1 0", done_cyc, ready_after, done_after, rise_cyc + 1);
    end
  endtask

  task automatic test_stale_done();
    compute_done = 1'b1;
    run_job(1, 1, 3, 6, 1, -1, 0);
    checks++;
    if (obs.size() != 3 || done_tiles != 3 || done_cnt != 1) begin
      errors++; $display("FAIL stale_counts: got starts %0d tiles %0d dones %0d expected 3 3 1", obs.size(), done_tiles, done_cnt);
    end
    for (int i = 1; i < obs.size(); i++) begin
      checks++;
      if (obs[i].cyc - obs[i-1].cyc != 8) begin
        errors++; $display("FAIL stale_spacing%0d: got %0d expected 8", i, obs[i].cyc - obs[i-1].cyc);
      end
    end
  endtask

  task automatic test_abort_wait();
    run_job(1, 1, 4, 5, 0, 1, 2);
    checks++;
    if (obs.size() != 2 || done_cnt != 1) begin
      errors++; $display("FAIL abort_starts: got starts %0d dones %0d expected 2 1", obs.size(), done_cnt);
    end
    checks++;
    if (done_aborted != 1 || done_tiles != 2) begin
      errors++; $display("FAIL abort_result: got aborted %0d tiles %0d expected 1 2", done_aborted, done_tiles);
    end
    checks++;
    if (done_cyc != rise_cyc + 1) begin
      errors++; $display("FAIL abort_done_cycle: got %0d expected %0d", done_cyc, rise_cyc + 1);
    end
  endtask

  task automatic test_zero_dim();
    compute_done = 1'b0;
    run_job(2, 3, 0, 5, 0, -1, 0);
    checks++;
    if (obs.size() != 0 || done_cyc != 1 || done_cnt != 1) begin
      errors++; $display("FAIL zero_timing: got starts %0d done_cyc %0d dones %0d expected 0 1 1", obs.size(), done_cyc, done_cnt);
    end
    checks++;
    if (done_tiles != 0 || done_aborted != 0 || ready_after != 1) begin
      errors++; $display("FAIL zero_result: got tiles %0d aborted %0d ready %0d expected 0 0 1", done_tiles, done_aborted, ready_after);
    end
  endtask

  task automatic test_abort_final();
    run_job(1, 1, 1, 5, 0, 0, 5);
    checks++;
    if (done_aborted != 0 || done_tiles != 1 || obs.size() != 1 || done_cnt != 1) begin
      errors++; $display("FAIL abort_final: got aborted %0d tiles %0d starts %0d dones %0d expected 0 1 1 1",
                         done_aborted, done_tiles, obs.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid_job();
    int stray;
    stray = 0;
    job_m = 4'd1; job_n = 4'd1; job_k = 4'd3;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    checks++;
    if (start_mul !== 1'b1) begin
      errors++; $display("FAIL rstmid_start: got %b expected 1", start_mul);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    arr_active = 1'b0;
    compute_done = 1'b0;
    checks++;
    if ({job_ready, start_mul, busy, job_done, job_aborted, first_k, last_k} !== 7'b1000000 ||
        {tile_m, tile_n, tile_k, tiles_done} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got ctrl %b done %0d expected 1000000 0",
                         {job_ready, start_mul, busy, job_done, job_aborted, first_k, last_k}, tiles_done);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (job_done || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL rstmid_quiet: got %0d busy/done cycles expected 0", stray);
    end
    run_job(1, 1, 1, 4, 0, -1, 0);
    checks++;
    if (obs.size() != 1 || done_tiles != 1 || done_aborted != 0 || done_cnt != 1 || obs[0].fk != 1 || obs[0].lk != 1) begin
      errors++; $display("FAIL rstmid_newjob: got starts %0d tiles %0d aborted %0d dones %0d expected 1 1 0 1",
                         obs.size(), done_tiles, done_aborted, done_cnt);
    end
  endtask

  task automatic test_random();
    int m, n, k, d;
    for (int it = 0; it < 6; it++) begin
      m = $urandom_range(1, 2);
      n = $urandom_range(1, 2);
      k = (it == 0) ? 15 : $urandom_range(1, 15);
      d = $urandom_range(2, 6);
      checks++;
      if (job_ready !== 1'b1) begin
        errors++; $display("FAIL rand%0d_ready: got %b expected 1", it, job_ready);
      end
      build_model(m, n, k);
      run_job(m, n, k, d, 0, -1, 0);
      checks++;
      if (obs.size() != exp_q.size() || done_cnt != 1) begin
        errors++; $display("FAIL rand%0d_starts: got %0d dones %0d expected %0d 1", it, obs.size(), done_cnt, exp_q.size());
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs[i].m != exp_q[i].m || obs[i].n != exp_q[i].n || obs[i].k != exp_q[i].k ||
            obs[i].fk != exp_q[i].fk || obs[i].lk != exp_q[i].lk ||
            obs[i].cyc != ((i == 0) ? 1 : obs[i-1].cyc + d + 2)) begin
          errors++;
          $display("FAIL rand%0d_tile%0d: got m%0d n%0d k%0d f%0d l%0d c%0d expected m%0d n%0d k%0d f%0d l%0d", it, i,
                   obs[i].m, obs[i].n, obs[i].k, obs[i].fk, obs[i].lk, obs[i].cyc,
                   exp_q[i].m, exp_q[i].n, exp_q[i].k, exp_q[i].fk, exp_q[i].lk);
        end
      end
      checks++;
      if (done_tiles != m * n * k || done_aborted != 0 || done_cyc != rise_cyc + 1) begin
        errors++; $display("FAIL rand%0d_result: got tiles %0d aborted %0d done_cyc %0d expected %0d 0 %0d",
                           it, done_tiles, done_aborted, done_cyc, m * n * k, rise_cyc + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_stale_done();
    test_abort_wait();
    test_zero_dim();
    test_abort_final();
    test_reset_mid_job();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vegeta_tile_scheduler.md
# vegeta_tile_scheduler

Sequences a full tiled GEMM job over the VEGETA array by driving the array controller's `start_multiplication` once per tile and waiting for its `compute_done` before issuing the next tile. It sits above the array controller and below the host command interface. It accepts a job of M×N×K tiles, walks tile indices with K innermost, then N, then M, and reports per-tile accumulate/writeback qualifiers to the buffer controllers. It supports graceful abort and reports completion with a one-cycle pulse.

## Interface
- `DIM_W`, default 4: width of each tile-count field and tile index.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `job_valid`  in  1  job request.
- `job_ready`  out  1  scheduler can accept a job.
- `job_m_tiles`, `job_n_tiles`, `job_k_tiles`  in  DIM_W each  tile counts; sampled on accept.
- `abort`  in  1  request to stop after the in-flight tile.
- `start_multiplication`  out  1  one-cycle start to the array controller.
- `compute_done`  in  1  array-controller done level; completion is its rising edge.
- `tile_m`, `tile_n`, `tile_k`  out  DIM_W each  indices of the tile currently issued.
- `first_k`  out  1  current tile has `tile_k==0`; accumulation buffer is zero-initialised.
- `last_k`  out  1  current tile has `tile_k==k_tiles-1`; output writeback is enabled.
- `busy`  out  1  high in every state except IDLE.
- `job_done`  out  1  one-cycle completion pulse.
- `job_aborted`  out  1  valid with `job_done`: tiles were skipped due to abort.
- `tiles_done`  out  3*DIM_W  count of completed tiles in the current or last job.

## Operation
- States: IDLE, ISSUE, WAIT, ADVANCE, DONE. `rst` forces IDLE.
- Reset values: all outputs 0 except `job_ready`=1. The internal `compute_done_q`, the latched dims and `abort_pending` are all 0.
- `compute_done_q` registers `compute_done` every cycle in every state. `done_rise = compute_done & ~compute_done_q`.
- **IDLE:**
  - `job_ready`=1.
  - On `job_valid&job_ready`: latch dims, zero the indices and `tiles_done`, clear `abort_pending`.
  - If any dim is 0, go to DONE with `job_aborted`=0. Otherwise go to ISSUE.
  - `abort` is ignored in IDLE.
- **ISSUE:**
  - `start_multiplication`=1, Moore output, exactly one cycle.
  - `tile_*`, `first_k` and `last_k` are stable from ISSUE through WAIT.
  - Next state is WAIT unconditionally.
- **WAIT:**
  - Hold until `done_rise`. A level already high from a previous tile is not completion.
  - On `done_rise`: `tiles_done`+=1.
  - If this is the last tile (m=M-1, n=N-1, k=K-1), go to DONE with `job_aborted`=0.
  - Else if `abort_pending` or `abort`, go to DONE with `job_aborted`=1.
  - Else go to ADVANCE.
- **ADVANCE:**
  - Advance the indices: k+1; on k wrap (k==K-1), k=0 and n+1; on n wrap, n=0 and m+1.
  - `first_k` and `last_k` are recomputed from the new k.
  - If `abort` is high this cycle, go to DONE with `job_aborted`=1. Else go to ISSUE.
- **DONE:**
  - `job_done`=1 for one cycle. `job_aborted` is valid only this cycle and is 0 otherwise.
  - `job_ready`=0.
  - Next state is IDLE.
- `abort` sampled high in ISSUE or WAIT sets `abort_pending`. The in-flight tile always completes; the array controller is never cut off mid-tile.
- `tiles_done` holds its value after DONE until the next accept.
- Index arithmetic is unsigned DIM_W bits. Counts of up to 2^DIM_W−1 are legal; wrap comparisons use count−1, so no overflow is possible.

## Timing
- Accept at edge e0 → ISSUE in cycle 1, with `start_multiplication` high in cycle 1.
- `done_rise` seen in cycle t (WAIT) → ADVANCE in cycle t+1 → next `start_multiplication` in cycle t+2. The inter-tile gap is 2 cycles.
- Last `done_rise` in cycle t → `job_done` in cycle t+1 → `job_ready`=1 in cycle t+2.
- A zero-dim job: accept at e0 → `job_done` in cycle 1 → IDLE in cycle 2. `tiles_done`=0.
- Simultaneous last-tile `done_rise` and `abort`: the job completes normally with `job_aborted`=0.
- `job_valid` during DONE or any busy state is not accepted, because `job_ready`=0.
- `rst` mid-job: next cycle is IDLE with all outputs at reset values. No `job_done` is emitted.

## Test plan
- **Full job, M=2, N=1, K=3, with the model asserting `compute_done` 5 cycles after each start:**
  - 6 starts, in tile order (0,0,0),(0,0,1),(0,0,2),(1,0,0),(1,0,1),(1,0,2).
  - `first_k` on k=0 tiles and `last_k` on k=2 tiles.
  - `tiles_done`=6 and a single `job_done` with `job_aborted`=0.
  - Inter-start spacing of exactly 7 cycles (5 cycles to done, plus ADVANCE and ISSUE).
- **Stale done level:** `compute_done` held high from a previous job and dropping 2 cycles after start, then rising → exactly one tile completion counted per start.
- **Abort pulse in WAIT of tile 1 of a 1×1×4 job** → the tile completes, `job_done` follows with `job_aborted`=1, `tiles_done`=2, and no third start.
- **Zero dimension, `job_k_tiles`=0** → no `start_multiplication`, `job_done` in cycle 1, `tiles_done`=0.
- **Abort in the same cycle as the final `done_rise` of a 1×1×1 job** → `job_aborted`=0, `tiles_done`=1.
- **`rst` asserted in WAIT, then a new 1×1×1 job** → outputs return to reset values the cycle after `rst`, no `job_done` for the killed job, and the new job runs normally.
